// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: request/result bundle between a requester and the serial right shifter
interface shift_right_seq_if #(parameter int Nbits = 5);
   logic start;
   logic arith;
   logic [Nbits-1:0] A;
   logic [Nbits-1:0] B;
   logic busy;
   logic done;
   logic [Nbits-1:0] OUT;
   logic Carry_Flag;
   logic Zero_Flag;
   logic Negative_Flag;
   modport master (
      output start, arith, A, B,
      input  busy, done, OUT, Carry_Flag, Zero_Flag, Negative_Flag
   );
   modport slave (
      input  start, arith, A, B,
      output busy, done, OUT, Carry_Flag, Zero_Flag, Negative_Flag
   );
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: serial logical/arithmetic right shifter, one bit per clock, with done pulse and flags
module shift_right_seq #(parameter int Nbits = 5) (
   input logic clk,
   input logic rst_n,
   shift_right_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [Nbits-1:0] NB  = Nbits[Nbits-1:0];
   localparam logic [Nbits-1:0] ONE = {{(Nbits-1){1'b0}}, 1'b1};
   state_t state;
   logic [Nbits-1:0] work, cnt, out_q, k, nxt;
   logic arith_q, carry, c_q, z_q, n_q;
   always_comb begin
      k   = (bus.B >= NB) ? NB : bus.B;
      nxt = {arith_q & work[Nbits-1], work[Nbits-1:1]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         work    <= '0;
         cnt     <= '0;
         arith_q <= 1'b0;
         carry   <= 1'b0;
         out_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b1;
         n_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               work    <= bus.A;
               cnt     <= k;
               arith_q <= bus.arith;
               carry   <= 1'b0;
               if (k == '0) begin
                  // zero-length shift publishes the operand unchanged with no carry out
                  state <= DONE;
                  out_q <= bus.A;
                  c_q   <= 1'b0;
                  z_q   <= (bus.A == '0);
                  n_q   <= bus.A[Nbits-1];
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               carry <= work[0];
               work  <= nxt;
               cnt   <= cnt - ONE;
               if (cnt == ONE) begin
                  state <= DONE;
                  out_q <= nxt;
                  c_q   <= work[0];
                  z_q   <= (nxt == '0);
                  n_q   <= nxt[Nbits-1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.busy          = (state == SHIFT);
   assign bus.done          = (state == DONE);
   assign bus.OUT           = out_q;
   assign bus.Carry_Flag    = c_q;
   assign bus.Zero_Flag     = z_q;
   assign bus.Negative_Flag = n_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed checks of timing, results and flags of the serial right shifter
module tb_shift_right_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int tests = 0;
   int fails = 0;
   shift_right_seq_if #(.Nbits(5)) bus ();
   shift_right_seq #(.Nbits(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk)
      if (bus.busy === 1'b1 && bus.done === 1'b1) begin
         fails++;
         $display("FAIL busy_done_overlap got busy=1 done=1 need not both high");
      end
   task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic ar,
                        output int nb, output logic dn, output logic dn2);
      @(negedge clk);
      bus.A = a; bus.B = b; bus.arith = ar; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.A = ~a; bus.B = 5'd0; bus.arith = ~ar;
      nb = 0;
      while (bus.busy === 1'b1 && nb < 20) begin
         nb++;
         @(negedge clk);
      end
      dn = bus.done;
      @(negedge clk);
      dn2 = bus.done;
   endtask
   task automatic test_reset();
      bus.start = 1'b0; bus.arith = 1'b0; bus.A = '0; bus.B = '0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         fails++; $display("FAIL reset_ctrl got busy/done=%b need 00", {bus.busy, bus.done});
      end
      tests++;
      if (bus.OUT !== 5'b00000) begin
         fails++; $display("FAIL reset_out got %b need 00000", bus.OUT);
      end
      tests++;
      if ({bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag} !== 3'b010) begin
         fails++; $display("FAIL reset_flags got CZN=%b need 010", {bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_shift(input string name, input logic [4:0] a, input logic [4:0] b, input logic ar,
                             input int exp_nb, input logic [4:0] exp_out, input logic [2:0] exp_czn);
      int nb;
      logic dn, dn2;
      do_op(a, b, ar, nb, dn, dn2);
      tests++;
      if (nb !== exp_nb) begin
         fails++; $display("FAIL %s_busy_cycles got %0d need %0d", name, nb, exp_nb);
      end
      tests++;
      if ({dn, dn2} !== 2'b10) begin
         fails++; $display("FAIL %s_done_pulse got %b need 10", name, {dn, dn2});
      end
      tests++;
      if (bus.OUT !== exp_out) begin
         fails++; $display("FAIL %s_out got %b need %b", name, bus.OUT, exp_out);
      end
      tests++;
      if ({bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag} !== exp_czn) begin
         fails++; $display("FAIL %s_flags got CZN=%b need %b", name, {bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag}, exp_czn);
      end
   endtask
   task automatic test_ignore_start();
      int nb;
      logic dn;
      @(negedge clk);
      bus.A = 5'b01100; bus.B = 5'd3; bus.arith = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      nb = 0;
      while (bus.busy === 1'b1 && nb < 20) begin
         nb++;
         bus.start = (nb == 1);
         bus.A = 5'b11111; bus.B = 5'd1; bus.arith = 1'b1;
         @(negedge clk);
      end
      bus.start = 1'b0;
      dn = bus.done;
      tests++;
      if (nb !== 3 || dn !== 1'b1) begin
         fails++; $display("FAIL ignore_timing got busy=%0d done=%b need 3 1", nb, dn);
      end
      tests++;
      if ({bus.OUT, bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag} !== {5'b00001, 3'b100}) begin
         fails++; $display("FAIL ignore_result got %b CZN=%b need 00001 100", bus.OUT, {bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag});
      end
      repeat (2) @(negedge clk);
      tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         fails++; $display("FAIL ignore_no_queue got busy/done=%b need 00", {bus.busy, bus.done});
      end
   endtask
   task automatic test_async_reset();
      logic seen_done = 1'b0;
      @(negedge clk);
      bus.A = 5'b10110; bus.B = 5'd4; bus.arith = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++; $display("FAIL abort_busy got %b need 1", bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.busy, bus.done, bus.OUT, bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag} !== {2'b00, 5'b00000, 3'b010}) begin
         fails++; $display("FAIL abort_outputs got busy/done=%b out=%b CZN=%b need 00 00000 010",
                           {bus.busy, bus.done}, bus.OUT, {bus.Carry_Flag, bus.Zero_Flag, bus.Negative_Flag});
      end
      repeat (3) begin
         @(negedge clk);
         seen_done |= bus.done;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         seen_done |= bus.done;
      end
      tests++;
      if (seen_done !== 1'b0) begin
         fails++; $display("FAIL abort_no_done got %b need 0", seen_done);
      end
   endtask
   initial begin
      test_reset();
      test_shift("logical2", 5'b10110, 5'd2, 1'b0, 2, 5'b00101, 3'b100);
      test_shift("arith2",   5'b10110, 5'd2, 1'b1, 2, 5'b11101, 3'b101);
      test_shift("zero_amt", 5'b10110, 5'd0, 1'b0, 0, 5'b10110, 3'b001);
      test_shift("sat_log",  5'b10110, 5'd7, 1'b0, 5, 5'b00000, 3'b110);
      test_shift("sat_arith",5'b10110, 5'd7, 1'b1, 5, 5'b11111, 3'b101);
      test_shift("full_amt", 5'b01011, 5'd5, 1'b1, 5, 5'b00000, 3'b010);
      test_ignore_start();
      test_async_reset();
      test_shift("post_reset", 5'b10011, 5'd1, 1'b1, 1, 5'b11001, 3'b101);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
